// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants issued while a fetch request is waiting.
module arb_starve_ctr
  import mips_mem_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count,
  output logic       at_limit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 4'hF)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q >= LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// with a bounded number of data grants allowed ahead of a waiting fetch.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_done_q, dm_done_d;

  logic        if_gnt_c, dm_gnt_c;
  logic        mem_en_c, mem_we_c;
  logic        starve_inc, starve_clr, starve_at_limit;
  logic [3:0]  starve_cnt;

  arb_starve_ctr #(
    .LIMIT (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .count    (starve_cnt),
    .at_limit (starve_at_limit)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rvalid_d = 1'b0;
    dm_done_d   = 1'b0;
    if_gnt_c    = 1'b0;
    dm_gnt_c    = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        dm_gnt_c = dm_req && (!if_req || !starve_at_limit);
        if_gnt_c = if_req && !dm_gnt_c;
        if (dm_gnt_c) begin
          state_d = DBUSY;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
        end else if (if_gnt_c) begin
          state_d = IBUSY;
          addr_d  = if_addr;
          we_d    = 1'b0;
        end
      end
      IBUSY: begin
        mem_en_c = 1'b1;
        if (mem_ready) begin
          state_d     = IDLE;
          if_rdata_d  = mem_rdata;
          if_rvalid_d = 1'b1;
        end
      end
      DBUSY: begin
        mem_en_c = 1'b1;
        mem_we_c = we_q;
        if (mem_ready) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturation is applied here so the counter never wraps past 15.
  assign starve_inc = dm_gnt_c && if_req && (starve_cnt != 4'hF);
  assign starve_clr = if_gnt_c || ((state_q == IDLE) && !if_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_done_q   <= dm_done_d;
    end
  end

  // Combinational outputs are masked during reset so no grant or access escapes.
  assign if_gnt    = if_gnt_c && !reset;
  assign dm_gnt    = dm_gnt_c && !reset;
  assign mem_en    = mem_en_c && !reset;
  assign mem_we    = mem_we_c && !reset;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, 3: maximum consecutive data grants while a fetch request waits; legal range 1..15.
REQ-002 Port clk input 1: clock; all state changes on its rising edge.
REQ-003 Port reset input 1: reset, synchronous, active-high; clock clk.
REQ-004 Port if_req input 1: fetch read request; held high until if_gnt.
REQ-005 Port if_addr input 32: fetch byte address.
REQ-006 Port if_gnt output 1: fetch request accepted this cycle.
REQ-007 Port if_rvalid output 1: one-cycle pulse; if_rdata valid.
REQ-008 Port if_rdata output 32: fetched instruction word.
REQ-009 Port dm_req input 1: data access request; held high until dm_gnt.
REQ-010 Port dm_we input 1: 1 = write, 0 = read.
REQ-011 Port dm_addr input 32: data byte address.
REQ-012 Port dm_wdata input 32: store data.
REQ-013 Port dm_gnt output 1: data request accepted this cycle.
REQ-014 Port dm_done output 1: one-cycle pulse; data access completed (read or write).
REQ-015 Port dm_rdata output 32: load data.
REQ-016 Port mem_en output 1: access active on the shared single-port memory.
REQ-017 Port mem_we output 1: write strobe, valid only with mem_en.
REQ-018 Port mem_addr output 32: word-aligned memory address, bits [1:0] forced to 00.
REQ-019 Port mem_wdata output 32: memory write data.
REQ-020 Port mem_rdata input 32: memory read data, valid with mem_ready.
REQ-021 Port mem_ready input 1: memory completes the current access this cycle.

Function
REQ-022 Three states SHALL exist: IDLE, IBUSY and DBUSY.
REQ-023 In IDLE, grants SHALL be combinational: if_gnt and dm_gnt are never both high.
- dm_gnt = dm_req && (!if_req || starve_cnt < STARVE_MAX).
- if_gnt = if_req && !dm_gnt.
REQ-024 A grant SHALL register the address, dm_we and dm_wdata, and move the block to IBUSY or DBUSY.
REQ-025 In IBUSY/DBUSY, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL come from the registered request; mem_we = 0 in IBUSY.
REQ-026 In IDLE, mem_en and mem_we SHALL be 0.
REQ-027 No grant SHALL be issued outside IDLE.
REQ-028 When mem_ready is high in IBUSY, the block SHALL register mem_rdata into if_rdata, pulse if_rvalid the next cycle and return to IDLE.
REQ-029 When mem_ready is high in DBUSY, the block SHALL pulse dm_done the next cycle and return to IDLE.
- dm_rdata SHALL be updated only for reads.
- dm_rdata and if_rdata SHALL hold their value otherwise.
REQ-030 Latency: grant in cycle N, mem_en in N+1; with mem_ready in N+1, rvalid/done in N+2, and a new grant is possible in N+2.
REQ-031 mem_ready SHALL be ignored in IDLE.
REQ-032 starve_cnt (4-bit) SHALL increment on each dm_gnt while if_req is high, saturating at 15.
REQ-033 starve_cnt SHALL clear on if_gnt, or in any IDLE cycle with if_req low.
REQ-034 Simultaneous requests with starve_cnt == STARVE_MAX SHALL grant fetch.
REQ-035 Request inputs SHALL be ignored while not in IDLE; pending requests SHALL be held by requesters.

Reset
REQ-036 Reset SHALL force IDLE, clear starve_cnt, and drive all outputs to 0, including the rdata registers.
REQ-037 Reset during IBUSY/DBUSY SHALL abandon the access: mem_en is 0 the following cycle, and no rvalid/done is produced for it.

Structure
REQ-038 Package mips_mem_pkg SHALL hold the state encoding (IDLE=0, IBUSY=1, DBUSY=2) and the STARVE_MAX default.
REQ-039 The starvation counter SHALL be a sub-module named arb_starve_ctr (inc, clr, count, at_limit); everything else stays in mem_port_arbiter.

Verification
REQ-040 Fetch only: if_req with if_addr=0x00400006, mem_ready one cycle after mem_en, mem_rdata=0x8C220004 -> mem_addr=0x00400004, if_rvalid at N+2, if_rdata=0x8C220004.
REQ-041 Write: dm_req, dm_we=1, dm_addr=0x10000010, dm_wdata=0xDEADBEEF, memory waits 3 cycles -> mem_en high for 3 cycles with mem_we=1 and the given data, one dm_done pulse, dm_rdata unchanged.
REQ-042 Starvation: if_req and dm_req held continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I.
REQ-043 Reset in the second cycle of DBUSY -> mem_en 0 on the next cycle, no dm_done, starve_cnt 0, next grant from IDLE.
REQ-044 mem_ready pulsed in IDLE with no requests -> no rvalid/done, all outputs remain 0.
REQ-045 Back-to-back reads with mem_ready immediate -> grants every 2 cycles; if_gnt and dm_gnt never both high (checked by assertion).
